// File: rtl/fifo_rr_push_arbiter_if.sv
// Push-side bundle between N producers, the arbiter and one FIFO.
// master: producers + FIFO side; slave: the arbiter.
interface fifo_rr_push_arbiter_if #(
    parameter int N     = 3,
    parameter int WIDTH = 2
);
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]       req_last;
    logic [N-1:0]       grant;
    logic               fifo_push_enable;
    logic [WIDTH-1:0]   fifo_push_data;
    logic               fifo_full_flag;
    logic               busy;

    modport master (
        output req, req_data, req_last, fifo_full_flag,
        input  grant, fifo_push_enable, fifo_push_data, busy
    );

    modport slave (
        input  req, req_data, req_last, fifo_full_flag,
        output grant, fifo_push_enable, fifo_push_data, busy
    );
endinterface

// File: rtl/fifo_rr_push_arbiter.sv
// Round-robin push arbiter with burst lock in front of one FIFO.
// Optional FIFO_ARB_STATS_EN adds per-requester saturating grant counters.
module fifo_rr_push_arbiter #(
    parameter int N     = 3,
    parameter int WIDTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    fifo_rr_push_arbiter_if.slave arb
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [N*16-1:0] grant_cnt
`endif
);
    localparam int L2_N = $clog2(N);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [L2_N-1:0] rr_ptr_q, rr_ptr_d;
    logic [L2_N-1:0] owner_q, owner_d;
    logic            busy_q, busy_d;
    logic [L2_N-1:0] winner;
    logic [L2_N-1:0] sel;
    logic            found;
    logic            accept;

    function automatic logic [L2_N-1:0] next_idx(input logic [L2_N-1:0] i);
        return (i == L2_N'(N - 1)) ? '0 : i + L2_N'(1);
    endfunction

    // Find first requester at or after rr_ptr, wrapping modulo N
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && arb.req[idx]) begin
                found  = 1'b1;
                winner = L2_N'(idx);
            end
        end
    end

    // State, pointer, owner and busy registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            busy_q   <= busy_d;
        end
    end

    // Next state: lock on a non-last beat, release and advance on last
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        busy_d   = busy_q;
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (arb.req_last[winner]) begin
                        rr_ptr_d = next_idx(winner);
                    end else begin
                        state_d = LOCKED;
                        owner_d = winner;
                        busy_d  = 1'b1;
                    end
                end
                LOCKED: begin
                    if (arb.req_last[owner_q]) begin
                        state_d  = IDLE;
                        busy_d   = 1'b0;
                        rr_ptr_d = next_idx(owner_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // Grant and FIFO push signals; nothing leaves while in reset or full
    always_comb begin
        sel       = (state_q == LOCKED) ? owner_q : winner;
        arb.grant = '0;
        if (rst_n && !arb.fifo_full_flag) begin
            unique case (state_q)
                LOCKED:  arb.grant[owner_q] = arb.req[owner_q];
                IDLE:    arb.grant[winner]  = found;
                default: ;
            endcase
        end
        arb.fifo_push_enable = |arb.grant;
        arb.fifo_push_data   = '0;
        if (arb.fifo_push_enable)
            arb.fifo_push_data = arb.req_data[int'(sel)*WIDTH +: WIDTH];
    end

    assign accept   = arb.fifo_push_enable;
    assign arb.busy = busy_q;

`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0] cnt_q, cnt_d;

    // Count accepted beats per requester, holding at all-ones
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N; i++) begin
            if (arb.grant[i] && cnt_q[i*16 +: 16] != 16'hFFFF)
                cnt_d[i*16 +: 16] = cnt_q[i*16 +: 16] + 16'd1;
        end
    end

    // Counter register, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_fifo_rr_push_arbiter.sv
// Bench for fifo_rr_push_arbiter: directed scenarios plus random traffic
// checked against a behavioural round-robin/burst model and a FIFO queue.
module tb_fifo_rr_push_arbiter;
    localparam int N     = 3;
    localparam int WIDTH = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_rr_push_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus();

`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    fifo_rr_push_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (bus)
`ifdef FIFO_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit               m_locked;
    int               m_owner;
    int               m_ptr;
    int               m_cnt[N];
    logic [WIDTH-1:0] fifo_q[$];
    bit               pop_en;

    // Per-step observed and expected values
    logic [N-1:0]     obs_g, exp_g;
    logic [WIDTH-1:0] obs_d, exp_d;
    logic             obs_e, obs_b, exp_b;
    logic [N*16-1:0]  obs_cnt;

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        g = '0;
        if (!rst_n || bus.fifo_full_flag) return g;
        if (m_locked) begin
            g[m_owner] = bus.req[m_owner];
            return g;
        end
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (bus.req[j]) begin
                g[j] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    // One clock: sample mid-cycle, then advance the model after the edge
    task automatic step();
        int w;
        #1;
        exp_g = model_grant();
        w = 0;
        for (int k = 0; k < N; k++) if (exp_g[k]) w = k;
        exp_d = (exp_g != '0) ? bus.req_data[w*WIDTH +: WIDTH] : '0;
        exp_b = m_locked;
        obs_g = bus.grant;
        obs_d = bus.fifo_push_data;
        obs_e = bus.fifo_push_enable;
        obs_b = bus.busy;
        obs_cnt = '0;
`ifdef FIFO_ARB_STATS_EN
        obs_cnt = grant_cnt;
`endif
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_locked = 1'b0;
            m_ptr    = 0;
            m_owner  = 0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
        end else if (exp_g != '0) begin
            if (m_cnt[w] < 65535) m_cnt[w]++;
            if (m_locked) begin
                if (bus.req_last[w]) begin
                    m_locked = 1'b0;
                    m_ptr    = (w + 1) % N;
                end
            end else if (bus.req_last[w]) begin
                m_ptr = (w + 1) % N;
            end else begin
                m_locked = 1'b1;
                m_owner  = w;
            end
        end
        if (pop_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (exp_g != '0) fifo_q.push_back(exp_d);
        bus.fifo_full_flag = (fifo_q.size() >= DEPTH);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        fifo_q.delete();
        bus.fifo_full_flag = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req = '1;
        bus.req_last = '1;
        bus.req_data = '1;
        step();
        checks++; if (obs_g !== 3'b000) begin errors++; $display("FAIL reset_grant got %b exp 000", obs_g); end
        checks++; if (obs_e !== 1'b0) begin errors++; $display("FAIL reset_push_en got %b exp 0", obs_e); end
        checks++; if (obs_d !== 2'b00) begin errors++; $display("FAIL reset_push_data got %b exp 00", obs_d); end
        step();
        checks++; if (obs_b !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", obs_b); end
        rst_n = 1'b1;
        fifo_q.delete();
        bus.fifo_full_flag = 1'b0;
        step();
        checks++; if (obs_g !== 3'b001) begin errors++; $display("FAIL reset_first_grant got %b exp 001", obs_g); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0]     g_t[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        logic [WIDTH-1:0] d_t[4] = '{2'b01, 2'b10, 2'b11, 2'b01};
        do_reset();
        pop_en = 1'b1;
        bus.req = 3'b111;
        bus.req_last = 3'b111;
        bus.req_data = {2'b11, 2'b10, 2'b01};
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (obs_g !== g_t[i]) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", i, obs_g, g_t[i]); end
            checks++; if (obs_d !== d_t[i]) begin errors++; $display("FAIL rr_data[%0d] got %b exp %b", i, obs_d, d_t[i]); end
        end
    endtask

    task automatic test_burst_lock();
        logic [N-1:0] g_t[4] = '{3'b010, 3'b010, 3'b010, 3'b100};
        logic         b_t[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        pop_en = 1'b1;
        bus.req = 3'b001;
        bus.req_last = 3'b111;
        step();
        bus.req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            bus.req_last = (i == 2 || i == 3) ? 3'b111 : 3'b101;
            bus.req_data = N*WIDTH'($urandom);
            step();
            checks++; if (obs_g !== g_t[i]) begin errors++; $display("FAIL burst_grant[%0d] got %b exp %b", i, obs_g, g_t[i]); end
            checks++; if (obs_b !== b_t[i]) begin errors++; $display("FAIL burst_busy[%0d] got %b exp %b", i, obs_b, b_t[i]); end
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        pop_en = 1'b0;
        bus.req = 3'b001;
        bus.req_last = 3'b111;
        for (int i = 0; i < 4; i++) begin
            bus.req_data = N*WIDTH'($urandom);
            step();
            checks++; if (obs_g !== 3'b001) begin errors++; $display("FAIL full_beat[%0d] got %b exp 001", i, obs_g); end
        end
        pop_en = 1'b1;
        step();
        checks++; if (obs_g !== 3'b000) begin errors++; $display("FAIL full_gate got %b exp 000", obs_g); end
        checks++; if (obs_e !== 1'b0) begin errors++; $display("FAIL full_push_en got %b exp 0", obs_e); end
        pop_en = 1'b0;
        step();
        checks++; if (obs_g !== 3'b001) begin errors++; $display("FAIL full_resume got %b exp 001", obs_g); end
        pop_en = 1'b1;
    endtask

    task automatic test_owner_gap();
        logic [N-1:0] r_t[6] = '{3'b101, 3'b100, 3'b100, 3'b101, 3'b101, 3'b100};
        logic [N-1:0] l_t[6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b101, 3'b100};
        logic [N-1:0] g_t[6] = '{3'b001, 3'b000, 3'b000, 3'b001, 3'b001, 3'b100};
        do_reset();
        pop_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.req = r_t[i];
            bus.req_last = l_t[i];
            bus.req_data = N*WIDTH'($urandom);
            step();
            checks++; if (obs_g !== g_t[i]) begin errors++; $display("FAIL gap_grant[%0d] got %b exp %b", i, obs_g, g_t[i]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        pop_en = 1'b1;
        bus.req = 3'b100;
        bus.req_last = 3'b000;
        step();
        checks++; if (obs_g !== 3'b100) begin errors++; $display("FAIL mid_start got %b exp 100", obs_g); end
        step();
        checks++; if (obs_b !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", obs_b); end
        rst_n = 1'b0;
        step();
        checks++; if (obs_g !== 3'b000) begin errors++; $display("FAIL mid_rst_grant got %b exp 000", obs_g); end
        rst_n = 1'b1;
        bus.req = 3'b111;
        bus.req_last = 3'b111;
        step();
        checks++; if (obs_b !== 1'b0) begin errors++; $display("FAIL mid_after_busy got %b exp 0", obs_b); end
        checks++; if (obs_g !== 3'b001) begin errors++; $display("FAIL mid_after_grant got %b exp 001", obs_g); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            bus.req = N'($urandom);
            bus.req_last = N'($urandom_range(0, 7) | $urandom_range(0, 7));
            bus.req_data = N*WIDTH'($urandom);
            pop_en = ($urandom_range(0, 3) != 0);
            step();
            checks++; if (obs_g !== exp_g) begin errors++; $display("FAIL rnd_grant[%0d] got %b exp %b", i, obs_g, exp_g); end
            checks++; if (obs_e !== (|exp_g)) begin errors++; $display("FAIL rnd_push_en[%0d] got %b exp %b", i, obs_e, |exp_g); end
            checks++; if (obs_d !== exp_d) begin errors++; $display("FAIL rnd_data[%0d] got %b exp %b", i, obs_d, exp_d); end
            checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL rnd_busy[%0d] got %b exp %b", i, obs_b, exp_b); end
`ifdef FIFO_ARB_STATS_EN
            for (int r = 0; r < N; r++) begin
                checks++; if (obs_cnt[r*16 +: 16] !== 16'(m_cnt[r])) begin errors++; $display("FAIL rnd_cnt%0d[%0d] got %0d exp %0d", r, i, obs_cnt[r*16 +: 16], m_cnt[r]); end
            end
`endif
        end
        rst_n = 1'b1;
        pop_en = 1'b1;
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        pop_en = 1'b1;
        bus.req = 3'b000;
        step();
        checks++; if (obs_cnt !== '0) begin errors++; $display("FAIL cnt_reset got %h exp 0", obs_cnt); end
        bus.req = 3'b001;
        bus.req_last = 3'b111;
        for (int i = 0; i < 65540; i++) begin
            step();
            checks++; if (obs_cnt[15:0] !== 16'(m_cnt[0])) begin errors++; $display("FAIL cnt_step[%0d] got %0d exp %0d", i, obs_cnt[15:0], m_cnt[0]); end
        end
        step();
        checks++; if (obs_cnt[15:0] !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat got %h exp ffff", obs_cnt[15:0]); end
        do_reset();
        bus.req = 3'b000;
        step();
        checks++; if (obs_cnt !== '0) begin errors++; $display("FAIL cnt_clear got %h exp 0", obs_cnt); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        bus.req = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        bus.fifo_full_flag = 1'b0;
        pop_en = 1'b1;
        m_locked = 1'b0;
        m_owner = 0;
        m_ptr = 0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_burst_lock();
        test_full_stall();
        test_owner_gap();
        test_reset_mid_burst();
        test_random();
`ifdef FIFO_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
